// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store-path narrowing block: store size codes and FSM states.
package store_narrow_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEAT_W = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/narrow_fit_check.sv
// Inverse of the load-path sign extension: is the register value exactly representable
// at the store width? Also flags the reserved size code.
module narrow_fit_check
  import store_narrow_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  output logic              fits_o,
  output logic              legal_size_o
);

  always_comb begin
    fits_o       = 1'b0;
    legal_size_o = 1'b1;
    case (size_i)
      SZ_BYTE: fits_o = (data_i[31:8]  == {24{data_i[7]}});
      SZ_HALF: fits_o = (data_i[31:16] == {16{data_i[15]}});
      SZ_WORD: fits_o = 1'b1;
      default: legal_size_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrower_16.sv
// Turns a 32-bit store request into byte/halfword beats on a 16-bit memory port;
// word stores take two beats, narrow stores one.
module store_narrower_16
  import store_narrow_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic [1:0]        out_be,
  output logic              out_last,
  output logic              out_fits,
  output logic              err_pulse
);

  state_e            state_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [15:0]       out_data_q;
  logic [15:0]       second_q;
  logic [1:0]        out_be_q;
  logic              out_last_q;
  logic              out_fits_q;
  logic              err_q;

  logic fits_c;
  logic legal_size_c;
  logic misalign_c;
  logic [15:0] first_half_c;
  logic [15:0] second_half_c;
  logic [1:0]  byte_be_c;

  narrow_fit_check u_fit (
    .data_i       (in_data),
    .size_i       (in_size),
    .fits_o       (fits_c),
    .legal_size_o (legal_size_c)
  );

  // Alignment rules and lane mapping for the request presented at the input.
  always_comb begin
    misalign_c    = ((in_size == SZ_HALF) && in_addr[0]) ||
                    ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00));
    first_half_c  = BIG_ENDIAN ? in_data[31:16] : in_data[15:0];
    second_half_c = BIG_ENDIAN ? in_data[15:0]  : in_data[31:16];
    byte_be_c     = (in_addr[0] ^ BIG_ENDIAN) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      second_q    <= '0;
      out_be_q    <= 2'b00;
      out_last_q  <= 1'b0;
      out_fits_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!legal_size_c || misalign_c) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= BEAT0;
              out_valid_q <= 1'b1;
              out_fits_q  <= fits_c;
              out_addr_q  <= {in_addr[ADDR_W-1:1], 1'b0};
              second_q    <= second_half_c;
              case (in_size)
                SZ_BYTE: begin
                  out_data_q <= {in_data[7:0], in_data[7:0]};
                  out_be_q   <= byte_be_c;
                  out_last_q <= 1'b1;
                end
                SZ_HALF: begin
                  out_data_q <= in_data[15:0];
                  out_be_q   <= 2'b11;
                  out_last_q <= 1'b1;
                end
                default: begin
                  out_data_q <= first_half_c;
                  out_be_q   <= 2'b11;
                  out_last_q <= 1'b0;
                end
              endcase
            end
          end
        end
        BEAT0: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end else begin
              // Second half of a word follows immediately, address wraps naturally.
              state_q    <= BEAT1;
              out_addr_q <= out_addr_q + ADDR_W'(2);
              out_data_q <= second_q;
              out_last_q <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_be    = out_be_q;
  assign out_last  = out_last_q;
  assign out_fits  = out_fits_q;
  assign err_pulse = err_q;

endmodule
